// File: rtl/unit2_pkg.sv
// unit2_pkg: definitions shared by the unit2 writeback stage and its scoreboard.
//   - Default register-file geometry (DEF_DATA_W, DEF_ADDR_W).
//   - Opcode encodings consumed by unit2 (OPE_*).
//   - writes_dd(): true when an opcode produces a destination-register result.
package unit2_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 6;

    localparam logic [5:0] OPE_LUI  = 6'b110000;
    localparam logic [5:0] OPE_ADD  = 6'b001100;
    localparam logic [5:0] OPE_ADDI = 6'b001000;
    localparam logic [5:0] OPE_SUB  = 6'b010100;
    localparam logic [5:0] OPE_SLL  = 6'b011100;
    localparam logic [5:0] OPE_SLLI = 6'b011000;
    localparam logic [5:0] OPE_SRL  = 6'b100100;
    localparam logic [5:0] OPE_SRLI = 6'b100000;
    localparam logic [5:0] OPE_SRA  = 6'b101100;
    localparam logic [5:0] OPE_SRAI = 6'b101000;

    // Low opcode bits selecting the MEM and IO classes; bit 3 then splits
    // load/IN (1, writes a destination) from store/OUT (0, no destination).
    localparam logic [2:0] OPE_MEM_LSB = 3'b111;
    localparam logic [2:0] OPE_IO_LSB  = 3'b011;

    function automatic logic writes_dd(input logic [5:0] ope);
        logic alu_op;
        alu_op = (ope == OPE_LUI)  || (ope == OPE_ADD)  || (ope == OPE_ADDI) ||
                 (ope == OPE_SUB)  || (ope == OPE_SLL)  || (ope == OPE_SLLI) ||
                 (ope == OPE_SRL)  || (ope == OPE_SRLI) || (ope == OPE_SRA)  ||
                 (ope == OPE_SRAI);
        return alu_op ||
               ((ope[2:0] == OPE_MEM_LSB) && ope[3]) ||
               ((ope[2:0] == OPE_IO_LSB)  && ope[3]);
    endfunction

endpackage

// File: rtl/unit2_scoreboard.sv
// unit2_scoreboard: per-register pending bits for the unit2 writeback stage.
//   Optional feature macro: UNIT2_WB_BYPASS_EN (a register being written this
//   cycle is not considered pending by the hazard check).
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears pending bits)
//   iss_vld         issue presents an instruction
//   iss_ope         opcode of the presented instruction
//   iss_ds, iss_dt  source registers
//   iss_dd          destination register
//   wr_mask         one bit per register written by any result channel this cycle
//   hazard          issue must stall this cycle
module unit2_scoreboard
    import unit2_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_vld,
    input  logic [5:0]              iss_ope,
    input  logic [ADDR_W-1:0]       iss_ds,
    input  logic [ADDR_W-1:0]       iss_dt,
    input  logic [ADDR_W-1:0]       iss_dd,
    input  logic [(1<<ADDR_W)-1:0]  wr_mask,
    output logic                    hazard
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] pending_eff;
    logic [NREG-1:0] set_mask;
    logic            dd_writes;

    assign dd_writes = writes_dd(iss_ope);

`ifdef UNIT2_WB_BYPASS_EN
    // The completing value is forwarded to the operand muxes, so a register
    // whose write lands this cycle no longer blocks issue.
    assign pending_eff = pending_q & ~wr_mask;
`else
    assign pending_eff = pending_q;
`endif

    always_comb begin
        hazard = 1'b0;
        if (iss_vld) begin
            if ((iss_ds != '0) && pending_eff[iss_ds])
                hazard = 1'b1;
            if ((iss_dt != '0) && pending_eff[iss_dt])
                hazard = 1'b1;
            if (dd_writes && (iss_dd != '0) && pending_eff[iss_dd])
                hazard = 1'b1;
        end
    end

    // Set is applied after clear: a newly accepted writer of r overrides the
    // result that completes for r on the same edge.
    always_comb begin
        set_mask = '0;
        if (iss_vld && !hazard && dd_writes && (iss_dd != '0))
            set_mask[iss_dd] = 1'b1;
        pending_d    = (pending_q & ~wr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

endmodule

// File: rtl/unit2_writeback.sv
// unit2_writeback: register file and writeback stage for unit2.
//   Optional feature macro: UNIT2_WB_BYPASS_EN (same-cycle forwarding of
//   result-channel data onto ds_val/dt_val, priority io > mem > alu).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   iss_vld/iss_ope/iss_ds/iss_dt/iss_dd   instruction from issue
//   ds_val, dt_val              combinational operand reads
//   hazard                      issue must stall (from the scoreboard)
//   alu_*, mem_*, io_*          result channels; addr 0 means no write
//   wb_conflict                 sticky: two channels hit one nonzero register
module unit2_writeback
    import unit2_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_vld,
    input  logic [5:0]        iss_ope,
    input  logic [ADDR_W-1:0] iss_ds,
    input  logic [ADDR_W-1:0] iss_dt,
    input  logic [ADDR_W-1:0] iss_dd,
    output logic [DATA_W-1:0] ds_val,
    output logic [DATA_W-1:0] dt_val,
    output logic              hazard,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_dd_val,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dd_val,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_dd_val,
    output logic              wb_conflict
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wb_conflict_q;
    logic              wb_conflict_d;
    logic [NREG-1:0]   wr_mask;
    logic              alu_we;
    logic              mem_we;
    logic              io_we;
    logic              collide;

    assign alu_we = (alu_addr != '0);
    assign mem_we = (mem_addr != '0);
    assign io_we  = (io_addr  != '0);

    // Later assignments win, giving io > mem > alu on a shared destination.
    // Entry 0 is never written, so it holds its reset value of zero.
    always_comb begin
        regs_d  = regs_q;
        wr_mask = '0;
        if (alu_we) begin
            regs_d[alu_addr]  = alu_dd_val;
            wr_mask[alu_addr] = 1'b1;
        end
        if (mem_we) begin
            regs_d[mem_addr]  = mem_dd_val;
            wr_mask[mem_addr] = 1'b1;
        end
        if (io_we) begin
            regs_d[io_addr]  = io_dd_val;
            wr_mask[io_addr] = 1'b1;
        end
    end

    always_comb begin
        collide = (alu_we && mem_we && (alu_addr == mem_addr)) ||
                  (alu_we && io_we  && (alu_addr == io_addr))  ||
                  (mem_we && io_we  && (mem_addr == io_addr));
        wb_conflict_d = wb_conflict_q | collide;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q        <= '{default: '0};
            wb_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            wb_conflict_q <= wb_conflict_d;
        end
    end

    assign wb_conflict = wb_conflict_q;

    always_comb begin
        ds_val = (iss_ds == '0) ? '0 : regs_q[iss_ds];
`ifdef UNIT2_WB_BYPASS_EN
        if (iss_ds != '0) begin
            if (io_addr == iss_ds)
                ds_val = io_dd_val;
            else if (mem_addr == iss_ds)
                ds_val = mem_dd_val;
            else if (alu_addr == iss_ds)
                ds_val = alu_dd_val;
        end
`endif
    end

    always_comb begin
        dt_val = (iss_dt == '0) ? '0 : regs_q[iss_dt];
`ifdef UNIT2_WB_BYPASS_EN
        if (iss_dt != '0) begin
            if (io_addr == iss_dt)
                dt_val = io_dd_val;
            else if (mem_addr == iss_dt)
                dt_val = mem_dd_val;
            else if (alu_addr == iss_dt)
                dt_val = alu_dd_val;
        end
`endif
    end

    unit2_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .iss_vld (iss_vld),
        .iss_ope (iss_ope),
        .iss_ds  (iss_ds),
        .iss_dt  (iss_dt),
        .iss_dd  (iss_dd),
        .wr_mask (wr_mask),
        .hazard  (hazard)
    );

endmodule

// File: tb/tb_unit2_writeback.sv
// Directed testbench for unit2_writeback. Expectations follow the build:
// with UNIT2_WB_BYPASS_EN a completing write unblocks and forwards in the
// same cycle, otherwise one cycle later.
module tb_unit2_writeback;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic              iss_vld;
    logic [5:0]        iss_ope;
    logic [ADDR_W-1:0] iss_ds;
    logic [ADDR_W-1:0] iss_dt;
    logic [ADDR_W-1:0] iss_dd;
    logic [DATA_W-1:0] ds_val;
    logic [DATA_W-1:0] dt_val;
    logic              hazard;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_dd_val;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dd_val;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_dd_val;
    logic              wb_conflict;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UNIT2_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    unit2_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .iss_vld     (iss_vld),
        .iss_ope     (iss_ope),
        .iss_ds      (iss_ds),
        .iss_dt      (iss_dt),
        .iss_dd      (iss_dd),
        .ds_val      (ds_val),
        .dt_val      (dt_val),
        .hazard      (hazard),
        .alu_addr    (alu_addr),
        .alu_dd_val  (alu_dd_val),
        .mem_addr    (mem_addr),
        .mem_dd_val  (mem_dd_val),
        .io_addr     (io_addr),
        .io_dd_val   (io_dd_val),
        .wb_conflict (wb_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic vld, input logic [5:0] ope,
                         input logic [ADDR_W-1:0] ds, input logic [ADDR_W-1:0] dt,
                         input logic [ADDR_W-1:0] dd);
        iss_vld = vld;
        iss_ope = ope;
        iss_ds  = ds;
        iss_dt  = dt;
        iss_dd  = dd;
    endtask

    task automatic no_results();
        alu_addr = '0;
        mem_addr = '0;
        io_addr  = '0;
    endtask

    initial begin
        rst = 1'b1;
        issue(1'b0, 6'b000000, '0, '0, '0);
        no_results();
        alu_dd_val = '0;
        mem_dd_val = '0;
        io_dd_val  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        issue(1'b1, 6'b000000, 6'd5, 6'd0, 6'd0);
        #1;
        chk("rst_ds_val", ds_val, 32'h0);
        chk("rst_dt_val", dt_val, 32'h0);
        chk("rst_hazard", {31'b0, hazard}, 32'h0);
        chk("rst_conflict", {31'b0, wb_conflict}, 32'h0);

        // Simple write, then writes to register 0 are dropped
        issue(1'b0, 6'b000000, '0, '0, '0);
        alu_addr = 6'd3; alu_dd_val = 32'h12345678;
        tick();
        no_results();
        issue(1'b0, 6'b000000, 6'd3, 6'd0, 6'd0);
        #1;
        chk("wr_reg3", ds_val, 32'h12345678);
        mem_addr = 6'd0; mem_dd_val = 32'hFFFFFFFF;
        io_addr  = 6'd0; io_dd_val  = 32'hFFFFFFFF;
        tick();
        issue(1'b0, 6'b000000, 6'd0, 6'd3, 6'd0);
        #1;
        chk("reg0_zero", ds_val, 32'h0);
        chk("reg3_keep", dt_val, 32'h12345678);

        // Load RAW on register 7
        issue(1'b1, 6'b001111, 6'd0, 6'd0, 6'd7);
        #1;
        chk("ld_issue_hz", {31'b0, hazard}, 32'h0);
        tick();
        issue(1'b1, 6'b001100, 6'd7, 6'd0, 6'd0);
        #1;
        chk("raw_hz_a", {31'b0, hazard}, 32'h1);
        tick();
        chk("raw_hz_b", {31'b0, hazard}, 32'h1);
        mem_addr = 6'd7; mem_dd_val = 32'h0000CAFE;
        #1;
        chk("raw_hz_wb", {31'b0, hazard}, BYP ? 32'h0 : 32'h1);
        if (BYP) chk("raw_fwd", ds_val, 32'h0000CAFE);
        tick();
        no_results();
        #1;
        chk("raw_hz_after", {31'b0, hazard}, 32'h0);
        chk("raw_ds_after", ds_val, 32'h0000CAFE);

        // IO WAW on register 9
        issue(1'b1, 6'b001011, 6'd0, 6'd0, 6'd9);
        #1;
        chk("in_issue_hz", {31'b0, hazard}, 32'h0);
        tick();
        issue(1'b1, 6'b001100, 6'd1, 6'd2, 6'd9);
        #1;
        chk("waw_hz_a", {31'b0, hazard}, 32'h1);
        tick();
        chk("waw_hz_b", {31'b0, hazard}, 32'h1);
        io_addr = 6'd9; io_dd_val = 32'h0000ABCD;
        #1;
        chk("waw_hz_wb", {31'b0, hazard}, BYP ? 32'h0 : 32'h1);
        tick();
        no_results();
        issue(1'b1, 6'b001100, 6'd9, 6'd2, 6'd9);
        #1;
        // Bypass build accepted the ADD at the IO edge, re-marking r9 pending.
        chk("waw_hz_after", {31'b0, hazard}, BYP ? 32'h1 : 32'h0);
        chk("io_reg9", ds_val, 32'h0000ABCD);
        issue(1'b0, 6'b000000, '0, '0, '0);
        alu_addr = 6'd9; alu_dd_val = 32'h00000077;
        tick();
        no_results();
        issue(1'b1, 6'b000011, 6'd0, 6'd0, 6'd9);
        #1;
        chk("out_hz", {31'b0, hazard}, 32'h0);
        tick();
        issue(1'b1, 6'b001100, 6'd9, 6'd0, 6'd9);
        #1;
        chk("out_no_pend", {31'b0, hazard}, 32'h0);
        chk("reg9_alu", ds_val, 32'h00000077);
        issue(1'b0, 6'b000000, '0, '0, '0);

        // Three-way and two-way collisions
        alu_addr = 6'd4; alu_dd_val = 32'd1;
        mem_addr = 6'd4; mem_dd_val = 32'd2;
        io_addr  = 6'd4; io_dd_val  = 32'd3;
        tick();
        alu_addr = 6'd5; alu_dd_val = 32'h10;
        mem_addr = 6'd5; mem_dd_val = 32'h20;
        io_addr  = 6'd0;
        tick();
        no_results();
        issue(1'b0, 6'b000000, 6'd4, 6'd5, 6'd0);
        #1;
        chk("coll_reg4", ds_val, 32'd3);
        chk("coll_reg5", dt_val, 32'h20);
        chk("coll_flag", {31'b0, wb_conflict}, 32'h1);
        tick();
        tick();
        chk("coll_sticky", {31'b0, wb_conflict}, 32'h1);

        // Reset during an in-flight load
        issue(1'b1, 6'b001111, 6'd0, 6'd0, 6'd7);
        tick();
        issue(1'b1, 6'b001100, 6'd7, 6'd0, 6'd0);
        #1;
        chk("mid_hz_pre", {31'b0, hazard}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_hz_post", {31'b0, hazard}, 32'h0);
        chk("mid_conflict", {31'b0, wb_conflict}, 32'h0);
        chk("mid_reg7_clr", ds_val, 32'h0);
        issue(1'b0, 6'b000000, 6'd7, 6'd4, 6'd0);
        mem_addr = 6'd7; mem_dd_val = 32'h55;
        tick();
        no_results();
        #1;
        chk("late_ld_reg7", ds_val, 32'h55);
        chk("rst_reg4_clr", dt_val, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
